// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit mini CPU.
// Owns pc, ir, a 4x8 register file and the {Z,C,V} flags; drives the external ALU.
module cpu_control_unit #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter bit         AUTO_START = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_en,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic [2:0]  flags,
  output logic [7:0]  pc,
  output logic        halted,
  output logic        instr_done,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] ALU_IDLE = 4'hF;
  localparam logic [3:0] ALU_PASS_B = 4'h8;

  state_t      state;
  logic [15:0] ir;
  logic [7:0]  result;
  logic [7:0]  regs [4];

  // Fields of the word arriving from memory (used in DECODE) and of the held ir
  logic [3:0] f_op;
  logic [1:0] f_rd, f_rs;
  logic [7:0] f_imm;
  logic [3:0] ir_op;
  logic [1:0] ir_rd;
  logic [7:0] ir_imm;

  assign f_op   = imem_rdata[15:12];
  assign f_rd   = imem_rdata[11:10];
  assign f_rs   = imem_rdata[9:8];
  assign f_imm  = imem_rdata[7:0];
  assign ir_op  = ir[15:12];
  assign ir_rd  = ir[11:10];
  assign ir_imm = ir[7:0];

  assign imem_addr = pc;
  assign dbg_data  = regs[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= 16'h0000;
      result     <= 8'h00;
      flags      <= 3'b000;
      imem_en    <= 1'b0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_opcode <= ALU_IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || AUTO_START) begin
            state   <= S_FETCH;
            imem_en <= 1'b1;
          end
        end
        S_FETCH: begin
          imem_en <= 1'b0;
          state   <= S_DECODE;
        end
        S_DECODE: begin
          // ALU operands are registered here from the incoming word so they
          // are stable for the whole EXECUTE cycle.
          ir    <= imem_rdata;
          state <= S_EXECUTE;
          if (f_op <= OP_CMP) begin
            alu_a      <= regs[f_rd];
            alu_b      <= regs[f_rs];
            alu_opcode <= f_op;
          end else if (f_op == OP_LDI) begin
            alu_a      <= regs[f_rd];
            alu_b      <= f_imm;
            alu_opcode <= ALU_PASS_B;
          end
        end
        S_EXECUTE: begin
          alu_a      <= 8'h00;
          alu_b      <= 8'h00;
          alu_opcode <= ALU_IDLE;
          result     <= (ir_op == OP_LDI) ? ir_imm : alu_result;
          case (ir_op)
            OP_JZ: begin
              pc         <= flags[2] ? ir_imm : pc + 8'd1;
              instr_done <= 1'b1;
              imem_en    <= 1'b1;
              state      <= S_FETCH;
            end
            OP_JMP: begin
              pc         <= ir_imm;
              instr_done <= 1'b1;
              imem_en    <= 1'b1;
              state      <= S_FETCH;
            end
            4'hD, 4'hE: begin
              pc         <= pc + 8'd1;
              instr_done <= 1'b1;
              imem_en    <= 1'b1;
              state      <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              flags <= {alu_zero, alu_carry, alu_overflow};
              state <= S_WRITEBACK;
            end
          endcase
        end
        S_WRITEBACK: begin
          if (ir_op != OP_CMP) regs[ir_rd] <= result;
          pc         <= pc + 8'd1;
          instr_done <= 1'b1;
          imem_en    <= 1'b1;
          state      <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a stand-in ALU and instruction memory.
// The stand-in ALU reports V as the carry/borrow out of bit 7 for ADD/SUB/CMP.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_opcode;
  logic        alu_zero, alu_carry, alu_overflow;
  logic [2:0]  flags;
  logic [7:0]  pc;
  logic        halted, instr_done;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int n;
  int done_snap;

  logic [15:0] imem [256];

  cpu_control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .flags(flags), .pc(pc), .halted(halted),
    .instr_done(instr_done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= imem[imem_addr];
  always @(posedge clk) if (instr_done) done_cnt++;

  logic [8:0] sum;
  always_comb begin
    sum          = 9'd0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      4'h0:       begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_overflow = sum[8]; end
      4'h1, 4'h9: begin sum = {1'b0, alu_a} - {1'b0, alu_b}; alu_overflow = sum[8]; end
      4'h2:       sum = {1'b0, alu_a & alu_b};
      4'h3:       sum = {1'b0, alu_a | alu_b};
      4'h4:       sum = {1'b0, alu_a ^ alu_b};
      4'h8:       sum = {1'b0, alu_b};
      default:    sum = 9'd0;
    endcase
    alu_result = sum[7:0];
    alu_carry  = sum[8];
    alu_zero   = (sum[7:0] == 8'h00);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, {8'h00, dbg_data}, {8'h00, exp});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts rising edges until instr_done is seen; gives up after 20.
  task automatic next_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!instr_done && cyc < 20);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dbg_sel = 2'd0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hD000;
    imem[0]     = 16'hA405;  // LDI r1,05
    imem[1]     = 16'hA4F0;  // LDI r1,F0
    imem[2]     = 16'hA820;  // LDI r2,20
    imem[3]     = 16'h0600;  // ADD r1,r2
    imem[4]     = 16'hA433;  // LDI r1,33
    imem[5]     = 16'hA833;  // LDI r2,33
    imem[6]     = 16'h9600;  // CMP r1,r2
    imem[7]     = 16'h1600;  // SUB r1,r2
    imem[8]     = 16'hB040;  // JZ 40
    imem[8'h40] = 16'hC0FF;  // JMP FF
    imem[8'hFF] = 16'hD000;  // NOP

    repeat (2) @(posedge clk); #1;
    chk("rst_pc", {8'h0, pc}, 16'h0000);
    chk("rst_flags", {13'h0, flags}, 16'h0000);
    chk("rst_halted", {15'h0, halted}, 16'h0000);
    chk("rst_imem_en", {15'h0, imem_en}, 16'h0000);
    chk("rst_done", {15'h0, instr_done}, 16'h0000);
    chk("rst_alu_op", {12'h0, alu_opcode}, 16'h000F);
    chk("rst_alu_a", {8'h0, alu_a}, 16'h0000);
    chk_reg("rst_r1", 2'd1, 8'h00);

    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_no_fetch", {15'h0, imem_en}, 16'h0000);

    pulse_start();
    next_done(n);
    chk("ldi_cycles", 16'(n), 16'd4);
    chk("ldi_pc", {8'h0, pc}, 16'h0001);
    chk_reg("ldi_r1", 2'd1, 8'h05);
    @(posedge clk); #1;
    chk("done_single", {15'h0, instr_done}, 16'h0000);

    next_done(n);
    next_done(n);
    next_done(n);
    chk("add_cycles", 16'(n), 16'd4);
    chk_reg("add_r1", 2'd1, 8'h10);
    chk("add_flags", {13'h0, flags}, 16'h0003);
    chk("add_pc", {8'h0, pc}, 16'h0004);

    next_done(n);
    next_done(n);
    next_done(n);
    chk("cmp_flags", {13'h0, flags}, 16'h0004);
    chk_reg("cmp_r1", 2'd1, 8'h33);
    next_done(n);
    chk_reg("sub_r1", 2'd1, 8'h00);
    chk("sub_flags", {13'h0, flags}, 16'h0004);
    chk("sub_pc", {8'h0, pc}, 16'h0008);

    next_done(n);
    chk("jz_cycles", 16'(n), 16'd3);
    chk("jz_pc", {8'h0, pc}, 16'h0040);
    next_done(n);
    chk("jmp_cycles", 16'(n), 16'd3);
    chk("jmp_pc", {8'h0, pc}, 16'h00FF);
    next_done(n);
    chk("nop_cycles", 16'(n), 16'd3);
    chk("nop_wrap_pc", {8'h0, pc}, 16'h0000);

    rst_n = 1'b0;
    imem[0] = 16'hF000;  // HALT
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    done_snap = done_cnt;
    repeat (5) @(posedge clk); #1;
    chk("halt_flag", {15'h0, halted}, 16'h0001);
    chk("halt_pc", {8'h0, pc}, 16'h0000);
    pulse_start();
    repeat (4) @(posedge clk); #1;
    chk("halt_start_ignored", {15'h0, halted}, 16'h0001);
    chk("halt_pc_frozen", {8'h0, pc}, 16'h0000);
    chk("halt_no_fetch", {15'h0, imem_en}, 16'h0000);
    chk("halt_no_done", 16'(done_cnt - done_snap), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", {15'h0, halted}, 16'h0000);
    chk("halt_rst_pc", {8'h0, pc}, 16'h0000);

    imem[0] = 16'hA007;  // LDI r0,07
    imem[1] = 16'h0000;  // ADD r0,r0
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    next_done(n);
    chk_reg("pre_r0", 2'd0, 8'h07);
    repeat (2) @(posedge clk); #1;
    chk("exec_alu_a", {8'h0, alu_a}, 16'h0007);
    chk("exec_alu_b", {8'h0, alu_b}, 16'h0007);
    chk("exec_alu_op", {12'h0, alu_opcode}, 16'h0000);
    done_snap = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_alu_op", {12'h0, alu_opcode}, 16'h000F);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk_reg("abort_r0", 2'd0, 8'h00);
    chk("abort_flags", {13'h0, flags}, 16'h0000);
    chk("abort_pc", {8'h0, pc}, 16'h0000);
    chk("abort_no_done", 16'(done_cnt - done_snap), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
